trig_pattern_gen: RTL and testbench

//   Transmit side of the held-trigger interface: drives a trigger line high for a

---
 rtl/trig_pattern_gen.sv | 108 ++++++++++
 tb/tb_trig_pattern_gen.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/trig_pattern_gen.sv
// Held-trigger pattern generator: emits repeat_n pulses of hold_len high cycles, each followed by GAP low cycles.
// Optional abort input enabled by defining TRIG_ABORT_EN.
module trig_pattern_gen #(
  parameter int unsigned LEN_W = 4,
  parameter int unsigned CNT_W = 4,
  parameter int unsigned GAP   = 2
) (
  input  logic             clk,
  input  logic             rst,
`ifdef TRIG_ABORT_EN
  input  logic             abort,
`endif
  input  logic             start,
  input  logic [LEN_W-1:0] hold_len,
  input  logic [CNT_W-1:0] repeat_n,
  output logic             trig_out,
  output logic             busy,
  output logic             done
);

  localparam int unsigned GAP_W = (GAP > 1) ? $clog2(GAP) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_HIGH = 2'd1;
  localparam logic [1:0] S_GAP  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]       state, state_nxt;
  logic [LEN_W-1:0] hold_cnt, hold_cnt_nxt;
  logic [LEN_W-1:0] hold_q, hold_q_nxt;
  logic [GAP_W-1:0] gap_cnt, gap_cnt_nxt;
  logic [CNT_W-1:0] pulse_cnt, pulse_cnt_nxt;
  logic [CNT_W-1:0] rep_q, rep_q_nxt;
  logic             abort_hit;

  // State, counters and registered Moore outputs derived from the next state
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      hold_cnt  <= '0;
      hold_q    <= '0;
      gap_cnt   <= '0;
      pulse_cnt <= '0;
      rep_q     <= '0;
      trig_out  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_nxt;
      hold_cnt  <= hold_cnt_nxt;
      hold_q    <= hold_q_nxt;
      gap_cnt   <= gap_cnt_nxt;
      pulse_cnt <= pulse_cnt_nxt;
      rep_q     <= rep_q_nxt;
      trig_out  <= (state_nxt == S_HIGH);
      busy      <= (state_nxt != S_IDLE);
      done      <= (state_nxt == S_DONE);
    end
  end

  // Next-state and counter logic; terminal counts are compared before incrementing
  always_comb begin
    state_nxt     = state;
    hold_cnt_nxt  = hold_cnt;
    hold_q_nxt    = hold_q;
    gap_cnt_nxt   = gap_cnt;
    pulse_cnt_nxt = pulse_cnt;
    rep_q_nxt     = rep_q;
    abort_hit     = 1'b0;
`ifdef TRIG_ABORT_EN
    abort_hit     = abort;
`endif
    case (state)
      S_IDLE: begin
        if (start) begin
          hold_q_nxt    = (hold_len == '0) ? LEN_W'(1) : hold_len;
          rep_q_nxt     = repeat_n;
          hold_cnt_nxt  = '0;
          gap_cnt_nxt   = '0;
          pulse_cnt_nxt = '0;
          state_nxt     = (repeat_n == '0) ? S_DONE : S_HIGH;
        end
      end
      S_HIGH: begin
        if (hold_cnt == hold_q - LEN_W'(1)) begin
          hold_cnt_nxt  = '0;
          pulse_cnt_nxt = pulse_cnt + CNT_W'(1);
          state_nxt     = S_GAP;
        end else begin
          hold_cnt_nxt = hold_cnt + LEN_W'(1);
        end
      end
      S_GAP: begin
        if (gap_cnt == GAP_W'(GAP - 1)) begin
          gap_cnt_nxt = '0;
          state_nxt   = (pulse_cnt == rep_q) ? S_DONE : S_HIGH;
        end else begin
          gap_cnt_nxt = gap_cnt + GAP_W'(1);
        end
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
    if (abort_hit && (state == S_HIGH || state == S_GAP))
      state_nxt = S_DONE;
  end

endmodule

// File: tb/tb_trig_pattern_gen.sv
// Self-checking bench for trig_pattern_gen: a timeline model queues expected per-cycle outputs,
// a monitor pops and compares one entry every cycle (idle outputs when the queue is empty).
module tb_trig_pattern_gen;

  localparam int unsigned GAP = 2;
  localparam int unsigned MAX_BUSY = 300;
`ifdef TRIG_ABORT_EN
  localparam bit ABORT_EN = 1'b1;
`else
  localparam bit ABORT_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       abort_sig;
  logic [3:0] hold_len;
  logic [3:0] repeat_n;
  logic       trig_out;
  logic       busy;
  logic       done;

  logic [2:0] exp_q[$];   // {trig_out, busy, done} per cycle
  int         rem;        // model busy cycles from the current cycle onward
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  int         busy_run = 0;

  trig_pattern_gen #(.LEN_W(4), .CNT_W(4), .GAP(GAP)) dut (
    .clk      (clk),
    .rst      (rst),
`ifdef TRIG_ABORT_EN
    .abort    (abort_sig),
`endif
    .start    (start),
    .hold_len (hold_len),
    .repeat_n (repeat_n),
    .trig_out (trig_out),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  // Monitor: one expected entry per cycle, sampled just after the edge
  initial begin
    logic [2:0] exp;
    logic [2:0] got;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      exp = (exp_q.size() > 0) ? exp_q.pop_front() : 3'b000;
      got = {trig_out, busy, done};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL outputs cyc=%0d got trig/busy/done=%b required=%b", cyc, got, exp);
      end
    end
  end

  // Watchdog: busy must not stay high longer than the longest legal run
  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (busy === 1'b1) busy_run++;
      else busy_run = 0;
      if (busy_run == int'(MAX_BUSY)) begin
        errors++;
        $display("FAIL timeout cyc=%0d busy held for %0d cycles without completing", cyc, busy_run);
      end
    end
  end

  // One cycle of stimulus; also advances the behavioural timeline
  task automatic step(input logic s, input logic [3:0] h, input logic [3:0] r,
                      input logic rs, input logic ab);
    int he;
    @(negedge clk);
    if (rem > 0) rem--;
    start     = s;
    hold_len  = h;
    repeat_n  = r;
    rst       = rs;
    abort_sig = ab & ABORT_EN;
    if (rs) begin
      exp_q.delete();
      rem = 0;
    end else if (abort_sig && rem > 1) begin
      exp_q.delete();
      exp_q.push_back(3'b011);
      rem = 2;
    end else if (s && rem == 0) begin
      he = (h == 0) ? 1 : int'(h);
      for (int p = 0; p < int'(r); p++) begin
        for (int i = 0; i < he; i++) exp_q.push_back(3'b110);
        for (int i = 0; i < int'(GAP); i++) exp_q.push_back(3'b010);
      end
      exp_q.push_back(3'b011);
      rem = int'(r) * (he + int'(GAP)) + 2;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 4'd0, 4'd0, 1'b0, 1'b0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort_sig = 1'b0; hold_len = '0; repeat_n = '0; rem = 0;
    step(1'b0, 4'd0, 4'd0, 1'b1, 1'b0);
    step(1'b0, 4'd0, 4'd0, 1'b1, 1'b0);
    checks++;
    if ({trig_out, busy, done} !== 3'b000) begin
      errors++;
      $display("FAIL reset state got trig/busy/done=%b required=000", {trig_out, busy, done});
    end
    idle(3);

    step(1'b1, 4'd3, 4'd1, 1'b0, 1'b0);
    idle(9);
    step(1'b1, 4'd0, 4'd2, 1'b0, 1'b0);
    idle(10);
    step(1'b1, 4'd7, 4'd0, 1'b0, 1'b0);
    idle(4);
    // Restarts mid-run are ignored
    step(1'b1, 4'd4, 4'd3, 1'b0, 1'b0);
    idle(1);
    step(1'b1, 4'd9, 4'd5, 1'b0, 1'b0);
    idle(5);
    step(1'b1, 4'd1, 4'd1, 1'b0, 1'b0);
    idle(16);
    // Reset during a pulse, then a normal run
    step(1'b1, 4'd5, 4'd1, 1'b0, 1'b0);
    idle(1);
    step(1'b0, 4'd0, 4'd0, 1'b1, 1'b0);
    idle(3);
    step(1'b1, 4'd2, 4'd2, 1'b0, 1'b0);
    idle(12);
    step(1'b1, 4'd6, 4'd2, 1'b0, 1'b0);
    idle(2);
    step(1'b0, 4'd0, 4'd0, 1'b0, 1'b1);
    idle(20);
    // Start held high: back-to-back runs with one idle cycle between
    for (int i = 0; i < 30; i++) step(1'b1, 4'd2, 4'd1, 1'b0, 1'b0);
    idle(8);
    step(1'b1, 4'd15, 4'd15, 1'b0, 1'b0);
    idle(260);

    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 3) == 0),
           4'($urandom_range(0, 15)),
           ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 3)),
           ($urandom_range(0, 199) == 0),
           ($urandom_range(0, 29) == 0));
    end
    step(1'b0, 4'd0, 4'd0, 1'b1, 1'b0);
    idle(5);

    if (checks < 12) begin
      errors++;
      $display("FAIL too few checks: %0d", checks);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
